// File: rtl/multi_voice_sine_reader_pkg.sv
// Shared widths, quadrant/state encodings and quarter-wave table contents
// for the multi-voice sine reader and its ROM.
package multi_voice_sine_reader_pkg;

    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 16;
    localparam int SAMPLE_W   = 16;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        OUTPUT
    } state_t;

    function automatic logic quadMirrored(input logic [1:0] quad);
        return (quad == QUAD_1) || (quad == QUAD_3);
    endfunction

    function automatic logic quadNegative(input logic [1:0] quad);
        return (quad == QUAD_2) || (quad == QUAD_3);
    endfunction

    // Entry a of the quarter wave, x = a/1024: floor(32767 * (3x - x^3) / 2),
    // a cubic sine fit that stays monotonic and within 0..32767.
    function automatic logic [ROM_DATA_W-1:0] quarterSine(input logic [ROM_ADDR_W-1:0] a);
        logic [31:0] lin;
        logic [31:0] cube;
        logic [47:0] prod;
        lin  = 32'(a) * 32'd3145728;
        cube = 32'(a) * 32'(a) * 32'(a);
        prod = 48'(lin - cube) * 48'd32767;
        return ROM_DATA_W'(prod >> 31);
    endfunction

endpackage

// File: rtl/multi_voice_sine_reader_sine_rom.sv
// 1024x16 registered-read quarter-wave sine table; dout follows addr by one clock.
module sine_rom
    import multi_voice_sine_reader_pkg::*;
(
    input  logic                  clk,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [ROM_DATA_W-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= quarterSine(addr);
    end

endmodule

// File: rtl/multi_voice_sine_reader.sv
// NUM_VOICES phase-accumulator sine voices sharing one quarter-wave ROM; each
// generate_next request advances the enabled voices and emits one mixed sample.
module multi_voice_sine_reader
    import multi_voice_sine_reader_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int STEP_W     = 20,
    parameter int PHASE_W    = 22,
    parameter int OUT_SHIFT  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES*STEP_W-1:0]   step_sizes,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic                           generate_next,
    output logic                           sample_ready,
    output logic signed [SAMPLE_W-1:0]     sample,
    output logic                           busy
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam logic [VIDX_W-1:0]       LAST_VOICE = VIDX_W'(NUM_VOICES - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN    = ~SAT_MAX;

    state_t                      state_q;
    logic [VIDX_W-1:0]           voice_q;
    logic [PHASE_W-1:0]          phase_q [NUM_VOICES];
    logic signed [SUM_W-1:0]     sum_q;
    logic [1:0]                  quad_q;
    logic                        en_q;
    logic signed [SAMPLE_W-1:0]  sample_q;
    logic                        ready_q;
    logic                        busy_q;

    logic [STEP_W-1:0]           step_sel;
    logic [PHASE_W-1:0]          phase_d;
    logic [1:0]                  quad_d;
    logic [ROM_ADDR_W-1:0]       frac_addr;
    logic [ROM_ADDR_W-1:0]       rom_addr;
    logic [ROM_DATA_W-1:0]       rom_dout;
    logic signed [SUM_W-1:0]     rom_ext;
    logic signed [SUM_W-1:0]     voice_val;
    logic signed [SUM_W-1:0]     sum_d;
    logic signed [SUM_W-1:0]     shifted;
    logic signed [SAMPLE_W-1:0]  sat_val;

    sine_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    // The ROM is addressed from the post-increment phase during ISSUE; mirrored
    // quadrants read the table backwards (1023 - a is simply ~a).
    always_comb begin
        step_sel  = step_sizes[int'(voice_q) * STEP_W +: STEP_W];
        phase_d   = phase_q[voice_q] + PHASE_W'(step_sel);
        quad_d    = phase_d[PHASE_W-1 -: 2];
        frac_addr = phase_d[PHASE_W-3 -: ROM_ADDR_W];
        rom_addr  = quadMirrored(quad_d) ? ~frac_addr : frac_addr;

        rom_ext   = signed'(SUM_W'(rom_dout));
        voice_val = '0;
        if (en_q) begin
            voice_val = quadNegative(quad_q) ? -rom_ext : rom_ext;
        end
        sum_d   = sum_q + voice_val;

        shifted = sum_q >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_val = SAMPLE_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            sat_val = SAMPLE_W'(SAT_MIN);
        end else begin
            sat_val = SAMPLE_W'(shifted);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            voice_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
            sum_q    <= '0;
            quad_q   <= QUAD_0;
            en_q     <= 1'b0;
            sample_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (generate_next) begin
                        sum_q   <= '0;
                        voice_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    en_q             <= voice_en[voice_q];
                    quad_q           <= quad_d;
                    phase_q[voice_q] <= voice_en[voice_q] ? phase_d : '0;
                    state_q          <= DATA;
                end
                DATA: begin
                    sum_q <= sum_d;
                    if (voice_q == LAST_VOICE) begin
                        state_q <= OUTPUT;
                    end else begin
                        voice_q <= voice_q + 1'b1;
                        state_q <= ISSUE;
                    end
                end
                OUTPUT: begin
                    sample_q <= sat_val;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample       = sample_q;
    assign sample_ready = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_multi_voice_sine_reader.sv
// Scoreboard bench for multi_voice_sine_reader: a four-voice mixer (no output
// shift) and a single-voice reader (shift 2) checked against a real-valued sine model.
module tb_multi_voice_sine_reader;

    logic clk = 1'b0;
    logic reset;

    logic [79:0]        stepM;
    logic [3:0]         enM;
    logic               genM;
    logic               readyM;
    logic               busyM;
    logic signed [15:0] sampleM;

    logic [19:0]        step1;
    logic [0:0]         en1;
    logic               gen1;
    logic               ready1;
    logic               busy1;
    logic signed [15:0] sample1;

    int phaseM [4];
    int phase1;
    int expQM [$];
    int expQ1 [$];
    int vectors     = 0;
    int miscompares = 0;

    multi_voice_sine_reader #(
        .NUM_VOICES (4),
        .STEP_W     (20),
        .PHASE_W    (22),
        .OUT_SHIFT  (0)
    ) dutMix (
        .clk           (clk),
        .reset         (reset),
        .step_sizes    (stepM),
        .voice_en      (enM),
        .generate_next (genM),
        .sample_ready  (readyM),
        .sample        (sampleM),
        .busy          (busyM)
    );

    multi_voice_sine_reader #(
        .NUM_VOICES (1),
        .STEP_W     (20),
        .PHASE_W    (22),
        .OUT_SHIFT  (2)
    ) dutSingle (
        .clk           (clk),
        .reset         (reset),
        .step_sizes    (step1),
        .voice_en      (en1),
        .generate_next (gen1),
        .sample_ready  (ready1),
        .sample        (sample1),
        .busy          (busy1)
    );

    always #5 clk = ~clk;

    // Quarter-wave table value: 32767 * (3x - x^3) / 2 at x = a/1024, floored.
    function automatic int romVal(input int a);
        real x;
        x = real'(a) / 1024.0;
        return int'($floor(32767.0 * (3.0 * x - x * x * x) / 2.0));
    endfunction

    // Signed sine value for a 22-bit phase using quarter-wave symmetry.
    function automatic int voiceSample(input int ph);
        int quadrant;
        int idx;
        int v;
        quadrant = ph / 1048576;
        idx      = (ph / 1024) % 1024;
        if (quadrant == 1 || quadrant == 3) idx = 1023 - idx;
        v = romVal(idx);
        return (quadrant >= 2) ? -v : v;
    endfunction

    function automatic int clamp16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic void clearModel();
        for (int v = 0; v < 4; v++) phaseM[v] = 0;
        phase1 = 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetAll();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearModel();
    endtask

    // Mixer request; voice_en switches to enLate just after clock changeAt and an
    // extra generate_next pulse is driven just after clock extraAt.
    task automatic applyStimulus(input logic [79:0] steps, input logic [3:0] en,
                                 input logic [3:0] enLate, input int changeAt, input int extraAt);
        int sum;
        int cycles;
        sum = 0;
        for (int v = 0; v < 4; v++) begin
            logic useEn;
            useEn = (2 * v + 1 > changeAt) ? enLate[v] : en[v];
            if (useEn) begin
                phaseM[v] = (phaseM[v] + int'(steps[v*20 +: 20])) % 4194304;
                sum += voiceSample(phaseM[v]);
            end else begin
                phaseM[v] = 0;
            end
        end
        expQM.push_back(clamp16(sum));

        @(negedge clk);
        stepM = steps;
        enM   = en;
        genM  = 1'b1;
        @(negedge clk);
        genM  = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) checkOutput("busyDuringMix", int'(busyM), 1);
            if (cycles == changeAt) enM = enLate;
            genM = (cycles == extraAt);
        end while (!readyM && cycles < 40);
        genM = 1'b0;
        checkOutput("latencyMix", cycles, 9);
        checkOutput("busyAfterMix", int'(busyM), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic applyStimulusSingle(input logic [19:0] step, input logic en);
        int cycles;
        if (en) begin
            phase1 = (phase1 + int'(step)) % 4194304;
            expQ1.push_back(clamp16(voiceSample(phase1) >>> 2));
        end else begin
            phase1 = 0;
            expQ1.push_back(0);
        end

        @(negedge clk);
        step1 = step;
        en1   = en;
        gen1  = 1'b1;
        @(negedge clk);
        gen1  = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ready1 && cycles < 20);
        checkOutput("latencySingle", cycles, 3);
        checkOutput("busyAfterSingle", int'(busy1), 0);
        repeat (2) @(posedge clk);
    endtask

    // Scoreboard monitors: every sample_ready pops one expected sample.
    always @(posedge clk) begin
        #1;
        if (readyM) begin
            if (expQM.size() == 0) begin
                checkOutput("unexpectedReadyMix", 1, 0);
            end else begin
                checkOutput("mixSample", int'(sampleM), expQM.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready1) begin
            if (expQ1.size() == 0) begin
                checkOutput("unexpectedReadySingle", 1, 0);
            end else begin
                checkOutput("singleSample", int'(sample1), expQ1.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [95:0] r96;
        logic [79:0] stepsR;
        logic [3:0]  enR;
        logic [3:0]  enLateR;
        int          changeR;
        int          extraR;

        reset = 1'b1;
        stepM = '0;
        enM   = '0;
        genM  = 1'b0;
        step1 = '0;
        en1   = '0;
        gen1  = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetSampleMix", int'(sampleM), 0);
        checkOutput("resetReadyMix", int'(readyM), 0);
        checkOutput("resetBusyMix", int'(busyM), 0);
        checkOutput("resetSampleSingle", int'(sample1), 0);
        checkOutput("resetReadySingle", int'(ready1), 0);
        checkOutput("resetBusySingle", int'(busy1), 0);

        $display("[TB] single voice quadrant walk");
        repeat (4) applyStimulusSingle(20'h80000, 1'b1);

        $display("[TB] single voice wrap-around");
        resetAll();
        repeat (5) applyStimulusSingle(20'hFFFFF, 1'b1);
        applyStimulusSingle(20'h12345, 1'b0);
        applyStimulusSingle(20'h3A5C7, 1'b1);

        $display("[TB] mixing and saturation");
        resetAll();
        applyStimulus({4{20'hFFC00}}, 4'hF, 4'hF, 99, 99);
        resetAll();
        applyStimulus({4{20'hFFC00}}, 4'h1, 4'h1, 99, 99);

        $display("[TB] requests while busy and in the output cycle");
        applyStimulus({20'h11111, 20'h2468A, 20'h0F0F0, 20'h7FFFF}, 4'hF, 4'hF, 99, 2);
        applyStimulus({20'h11111, 20'h2468A, 20'h0F0F0, 20'h7FFFF}, 4'hF, 4'hF, 99, 8);

        $display("[TB] voice enables changed mid-request");
        applyStimulus({20'h33333, 20'h54321, 20'h0ABCD, 20'h9C400}, 4'hF, 4'b1010, 2, 99);
        applyStimulus({20'h33333, 20'h54321, 20'h0ABCD, 20'h9C400}, 4'b1011, 4'b1011, 99, 99);

        $display("[TB] reset during a request");
        @(negedge clk);
        stepM = {20'h40000, 20'h30000, 20'h20000, 20'h10000};
        enM   = 4'hF;
        genM  = 1'b1;
        @(negedge clk);
        genM  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abortBusy", int'(busyM), 0);
        checkOutput("abortReady", int'(readyM), 0);
        checkOutput("abortSample", int'(sampleM), 0);
        applyStimulus({20'h40000, 20'h30000, 20'h20000, 20'h10000}, 4'hF, 4'hF, 99, 99);

        $display("[TB] randomized mixer requests");
        for (int n = 0; n < 24; n++) begin
            r96     = {$urandom(), $urandom(), $urandom()};
            stepsR  = r96[79:0];
            enR     = 4'($urandom_range(0, 15));
            enLateR = 4'($urandom_range(0, 15));
            changeR = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 99;
            extraR  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 99;
            applyStimulus(stepsR, enR, enLateR, changeR, extraR);
        end

        $display("[TB] randomized single-voice requests");
        for (int n = 0; n < 8; n++) begin
            applyStimulusSingle(20'($urandom()), 1'($urandom_range(0, 3) != 0));
        end

        repeat (4) @(posedge clk);
        checkOutput("pendingMix", expQM.size(), 0);
        checkOutput("pendingSingle", expQ1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
